// File: rtl/crt_pixel_arbiter_pkg.sv
// crt_pixel_arbiter_pkg: FSM encodings, pixel field widths and the captured-pixel type
// shared by the CRT pixel arbiter and its pick encoder.
package crt_pixel_arbiter_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EMIT = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    localparam int X_W = 10;
    localparam int Y_W = 10;
    localparam int B_W = 3;

    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
        logic [B_W-1:0] b;
    } pixel_t;

endpackage

// File: rtl/crt_arb_pick.sv
// crt_arb_pick: combinational winner select; rotating search from ptr in round-robin
// mode, lowest starved-else-lowest eligible index in fixed-priority mode.
module crt_arb_pick #(
    parameter int N_REQ = 3
) (
    input  logic [N_REQ-1:0] eligible,
    input  logic [1:0]       ptr,
    input  logic [N_REQ-1:0] starved,
    input  logic             mode,
    output logic [1:0]       winner,
    output logic             any
);

    logic [3:0] el4;
    logic [3:0] st4;
    logic [1:0] idx;

    // Walk from the lowest search position last so it overwrites later candidates.
    always_comb begin
        el4 = 4'(eligible);
        st4 = 4'(starved);
        idx = '0;
        winner = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = mode ? 2'(i) : 2'((int'(ptr) + i) % N_REQ);
            if (mode && |st4 ? st4[idx] : el4[idx]) winner = idx;
        end
    end

    assign any = |eligible;

endmodule

// File: rtl/crt_pixel_arbiter.sv
// crt_pixel_arbiter: grants one pixel source at a time onto the CRT pixel port with a
// rate-limited one-cycle strobe. CRT_ARB_STATS_EN adds per-requester grant counters.
module crt_pixel_arbiter
    import crt_pixel_arbiter_pkg::*;
#(
    parameter int N_REQ        = 3,
    parameter int MIN_GAP      = 4,
    parameter int PRIO_MODE    = 0,
    parameter int STARVE_LIMIT = 255
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_frame_tick,
    input  logic [N_REQ-1:0]       i_enable_mask,
    input  logic [N_REQ-1:0]       i_req_valid,
    output logic [N_REQ-1:0]       o_req_ready,
    input  logic [N_REQ*X_W-1:0]   i_req_x,
    input  logic [N_REQ*Y_W-1:0]   i_req_y,
    input  logic [N_REQ*B_W-1:0]   i_req_brightness,
`ifdef CRT_ARB_STATS_EN
    input  logic                   i_stat_clear,
    output logic [N_REQ*16-1:0]    o_stat_grants,
`endif
    output logic [X_W-1:0]         o_pixel_x,
    output logic [Y_W-1:0]         o_pixel_y,
    output logic [B_W-1:0]         o_pixel_brightness,
    output logic                   o_pixel_valid,
    output logic [1:0]             o_grant_id,
    output logic                   o_busy
);

    localparam int GW = $clog2(MIN_GAP) + 1;

    logic [1:0]       state;
    logic [1:0]       ptr;
    logic [1:0]       winner;
    logic [GW-1:0]    gap_cnt;
    logic [N_REQ-1:0] eligible;
    logic [N_REQ-1:0] starved;
    logic [7:0]       starve_cnt [N_REQ];
    logic             any;
    logic             xfer;
    pixel_t           pix;

    assign eligible = i_req_valid & i_enable_mask;

    crt_arb_pick #(.N_REQ(N_REQ)) u_pick (
        .eligible (eligible),
        .ptr      (ptr),
        .starved  (starved),
        .mode     (PRIO_MODE != 0),
        .winner   (winner),
        .any      (any)
    );

    // Ready is held low during reset so the handshake cannot fire while state is forced.
    assign xfer        = state == ST_IDLE && any && !i_rst;
    assign o_req_ready = xfer ? N_REQ'(1) << winner : '0;

    always_comb begin
        starved = '0;
        for (int k = 0; k < N_REQ; k++)
            starved[k] = eligible[k] && starve_cnt[k] >= 8'(STARVE_LIMIT);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int k = 0; k < N_REQ; k++) starve_cnt[k] <= '0;
        end else begin
            for (int k = 0; k < N_REQ; k++)
                starve_cnt[k] <= (!eligible[k] || o_req_ready[k]) ? '0
                               : starve_cnt[k] + 8'(starve_cnt[k] != 8'hff);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= ST_IDLE;
            ptr        <= '0;
            gap_cnt    <= '0;
            pix        <= '0;
            o_grant_id <= '0;
        end else begin
            case (state)
                ST_IDLE: state <= any ? ST_EMIT : ST_IDLE;
                ST_EMIT: begin
                    gap_cnt <= GW'(MIN_GAP - 2);
                    state   <= MIN_GAP > 2 ? ST_GAP : ST_IDLE;
                end
                ST_GAP: begin
                    gap_cnt <= gap_cnt - 1'b1;
                    state   <= gap_cnt == 1 ? ST_IDLE : ST_GAP;
                end
                default: state <= ST_IDLE;
            endcase
            if (xfer) begin
                pix        <= {i_req_x[winner*X_W +: X_W], i_req_y[winner*Y_W +: Y_W],
                               i_req_brightness[winner*B_W +: B_W]};
                o_grant_id <= winner;
            end
            // A frame tick restarts the rotation even when it lands on a grant.
            if (i_frame_tick) ptr <= '0;
            else if (xfer) ptr <= winner == 2'(N_REQ - 1) ? '0 : winner + 2'd1;
        end
    end

    assign o_pixel_x          = pix.x;
    assign o_pixel_y          = pix.y;
    assign o_pixel_brightness = pix.b;
    assign o_pixel_valid      = state == ST_EMIT;
    assign o_busy             = state != ST_IDLE;

`ifdef CRT_ARB_STATS_EN
    logic [15:0] live [N_REQ];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_stat_grants <= '0;
            for (int k = 0; k < N_REQ; k++) live[k] <= '0;
        end else if (i_stat_clear) begin
            o_stat_grants <= '0;
            for (int k = 0; k < N_REQ; k++) live[k] <= '0;
        end else begin
            for (int k = 0; k < N_REQ; k++) begin
                if (i_frame_tick) o_stat_grants[k*16 +: 16] <= live[k];
                live[k] <= i_frame_tick ? 16'(o_req_ready[k])
                         : live[k] + 16'(o_req_ready[k] && live[k] != 16'hffff);
            end
        end
    end
`endif

endmodule

// File: doc/crt_pixel_arbiter.md
Name: crt_pixel_arbiter

Overview:
Shares the single pixel-write port of the CRT phosphor display between several pixel sources, such as the test animation, the CPU display IOT and a debug overlay. It arbitrates among the requesters and accepts one pixel per grant over a valid/ready handshake. It drives a one-cycle pixel strobe into the CRT, rate-limited so the CRT input FIFO cannot overrun. Sits in the pixel clock domain, between the pixel sources and the CRT display module.

Parameters:
N_REQ, 3, number of requesters (2..4); requester 0 = highest fixed priority
MIN_GAP, 4, minimum cycles between output strobe rising edges (>=2)
PRIO_MODE, 0, 0 = round-robin, 1 = fixed priority with anti-starvation
STARVE_LIMIT, 255, in fixed-priority mode, waiting cycles after which a pending requester is force-granted (8-bit counters)

Ports:
i_clk  in  1  pixel clock
i_rst  in  1  asynchronous active-high reset
i_frame_tick  in  1  single-cycle start-of-frame pulse
i_enable_mask  in  N_REQ  per-requester enable; masked requesters are never granted
i_req_valid  in  N_REQ  pixel pending, per requester
o_req_ready  out  N_REQ  accept strobe, per requester
i_req_x  in  N_REQ*10  packed X coordinates, requester k at [10k+9:10k]
i_req_y  in  N_REQ*10  packed Y coordinates
i_req_brightness  in  N_REQ*3  packed brightness
o_pixel_x  out  10  to CRT pixel X
o_pixel_y  out  10  to CRT pixel Y
o_pixel_brightness  out  3  to CRT pixel brightness
o_pixel_valid  out  1  one-cycle pixel strobe to CRT
o_grant_id  out  2  index of the last granted requester
o_busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset values: all outputs 0; FSM = IDLE; round-robin pointer = 0; gap counter = 0; starvation counters = 0.
- Eligible requesters: i_req_valid & i_enable_mask.
- Transfer occurs when o_req_ready[k] && i_req_valid[k].
- FSM states:
  - IDLE: if any requester is eligible, compute the winner combinationally. Assert o_req_ready[winner] only, in the same cycle. Capture its x/y/brightness; set o_grant_id; go to EMIT. Otherwise stay in IDLE.
  - EMIT: o_pixel_valid = 1 for exactly this one cycle. Pixel fields are held stable from capture until the next capture. Load gap counter with MIN_GAP-2; go to GAP.
  - GAP: decrement the counter; when it reaches 0, go to IDLE. o_req_ready is all-zero in EMIT and GAP.
- Latency: o_pixel_valid rises 1 cycle after transfer. Sustained throughput is one pixel every MIN_GAP cycles.
- o_req_ready is one-hot or zero at all times, and is never asserted to a masked or non-valid requester.
- Round-robin (PRIO_MODE=0):
  - Search starts at the pointer and wraps modulo N_REQ.
  - After a grant to k, pointer = (k+1) mod N_REQ.
  - i_frame_tick resets the pointer to 0, taking effect at the next arbitration. If the tick coincides with a grant, the reset wins.
- Fixed priority (PRIO_MODE=1):
  - The lowest index wins.
  - Each eligible, non-granted requester increments its saturating starvation counter each cycle; a grant or deassertion of valid clears it.
  - A counter reaching STARVE_LIMIT overrides priority. If several reach the limit, the lowest index among them wins.
- A requester that drops valid before being granted is not an error and no state is kept for it.
- Mask changes take effect at the next IDLE arbitration; a transfer in flight completes.
- Asynchronous i_rst mid-EMIT aborts the strobe immediately: o_pixel_valid = 0.

Optional Feature:
CRT_ARB_STATS_EN:
- Defined: adds output o_stat_grants (N_REQ*16) and input i_stat_clear.
  - Per-requester 16-bit saturating grant counters, latched into the output register on i_frame_tick.
  - Live counters reset after the latch. If the same cycle also holds a grant, the live counter resets to 1 (the new grant is counted).
  - i_stat_clear zeroes both the live and latched counters.
- Undefined: no stats ports and no counters; arbitration is identical.

Decomposition:
- Shared package/definitions: FSM state encodings (IDLE/EMIT/GAP), pixel field widths (X/Y=10, brightness=3), packed-lane slicing constants.
- Natural sub-module: crt_arb_pick, a combinational rotate/priority encoder. Inputs: eligible vector, pointer, starved vector, mode. Outputs: winner index and any-flag. It is reusable for both modes.

Test Plan:
- Reset then idle: all valids 0 for 100 cycles -> o_pixel_valid and o_req_ready stay 0, o_busy = 0.
- RR fairness (N_REQ=3, MIN_GAP=4), all requesters valid continuously -> grants 0,1,2,0,1,2; strobes spaced exactly 4 cycles; each o_pixel_x equals the granted lane's X (e.g. 100/200/300).
- Single transfer, requester 1 only, x=512, y=384, brightness=7 -> ready[1] for one cycle; next cycle o_pixel_valid = 1 with 512/384/7; o_grant_id = 1.
- Masking: i_enable_mask = 3'b101, all valid -> requester 1 is never granted; grants alternate 0,2.
- Fixed priority, STARVE_LIMIT=8: requesters 0 and 2 held valid -> requester 2 is granted within 8 cycles of becoming pending, then 0 resumes.
- Frame tick coinciding with a grant to 1 -> next grant is requester 0, not 2. Assert i_rst during EMIT -> o_pixel_valid = 0 immediately and FSM returns to IDLE.
